// File: rtl/video_line_fetch_sched_if.sv
// Data-mover request channel between the line fetch scheduler and the AXI data mover.
// The scheduler holds the request fields steady while dma_valid is high.
interface video_line_fetch_sched_if #(
  parameter int unsigned AddrWidth = 64
);
  logic                 dma_valid;
  logic                 dma_ready;
  logic [AddrWidth-1:0] dma_src;
  logic [AddrWidth-1:0] dma_dst;
  logic [AddrWidth-1:0] dma_len;

  modport master (
    output dma_valid, dma_src, dma_dst, dma_len,
    input  dma_ready
  );

  modport slave (
    input  dma_valid, dma_src, dma_dst, dma_len,
    output dma_ready
  );
endinterface

// File: rtl/video_line_fetch_sched.sv
// Scanline fetch scheduler: issues one data-mover copy per framebuffer line into a ping-pong line buffer.
// Optional LINE_DOUBLE_EN shows every source line on two display lines (one fetch per line pair).
module video_line_fetch_sched #(
  parameter int unsigned AddrWidth = 64,
  parameter int unsigned HalfBytes = 16384,
  parameter int unsigned CntWidth  = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      enable_i,
  input  logic                      frame_start_i,
  input  logic                      line_start_i,
  input  logic [AddrWidth-1:0]      fb_base_i,
  input  logic [13:0]               fb_bpl_i,
  input  logic [11:0]               fb_height_i,
  input  logic [14:0]               line_bytes_i,
  video_line_fetch_sched_if.master  dma,
  output logic                      disp_half_o,
  output logic                      busy_o,
  output logic                      underrun_o,
  output logic [CntWidth-1:0]       underrun_cnt_o
);

  localparam int unsigned LineW   = 13;
  localparam int unsigned HeightW = 12;
  localparam int unsigned CntSumW = CntWidth + 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_RUN,
    ST_DONE_WAIT
  } state_e;

  state_e state_q, state_d;

  logic                 pending_q, pending_d;
  logic [AddrWidth-1:0] pend_src_q, pend_src_d;
  logic                 pend_half_q, pend_half_d;
  logic [HeightW-1:0]   pend_line_q, pend_line_d;
  logic [AddrWidth-1:0] src_next_q, src_next_d;
  logic [LineW-1:0]     line_idx_q, line_idx_d;
  logic [HeightW-1:0]   cur_line_q, cur_line_d;
  logic                 cur_stale_q, cur_stale_d;
  logic                 done_vld_q, done_vld_d;
  logic [HeightW-1:0]   done_line_q, done_line_d;
  logic                 disp_half_q, disp_half_d;
  logic [CntWidth-1:0]  cnt_q, cnt_d;
  logic                 underrun_q, underrun_d;
  logic                 valid_q, valid_d;
  logic [AddrWidth-1:0] src_q, src_d;
  logic [AddrWidth-1:0] dst_q, dst_d;
  logic [AddrWidth-1:0] len_q, len_d;
  logic                 busy_q, busy_d;

  logic [LineW-1:0]     fidx;
  logic                 q_slot;
  logic [LineW-1:0]     height_x;
  logic [LineW-1:0]     nf;
  logic                 frame_ev, line_ev, line_q, queue;
  logic [AddrWidth-1:0] q_src;
  logic                 q_half;
  logic [HeightW-1:0]   q_line;
  logic                 done_now, fetch_ok;
  logic                 ur_line, ur_repl;
  logic [AddrWidth-1:0] bpl_x;
  logic [CntSumW-1:0]   cnt_sum;
  logic                 iss_half;

  // Fetch index for the current display line and whether this line start may queue a fetch
`ifdef LINE_DOUBLE_EN
  assign fidx   = {1'b0, line_idx_q[LineW-1:1]};
  assign q_slot = line_idx_q[0];
`else
  assign fidx   = line_idx_q;
  assign q_slot = 1'b1;
`endif

  assign height_x = {1'b0, fb_height_i};
  assign nf       = fidx + LineW'(1);
  assign bpl_x    = AddrWidth'(fb_bpl_i);

  // Frame start wins over a coincident line start
  assign frame_ev = enable_i & frame_start_i;
  assign line_ev  = enable_i & line_start_i & ~frame_start_i & (fidx < height_x);
  assign line_q   = line_ev & q_slot & (nf < height_x);
  assign queue    = frame_ev | line_q;

  assign q_src  = frame_ev ? fb_base_i : src_next_q;
  assign q_half = frame_ev ? 1'b0 : ~fidx[0];
  assign q_line = frame_ev ? '0 : nf[HeightW-1:0];

  // A fetch finishing in the same cycle as its line start still counts as on time
  assign done_now = (state_q == ST_DONE_WAIT) & dma.dma_ready;
  assign fetch_ok = (done_vld_q & (done_line_q == fidx[HeightW-1:0])) |
                    (done_now & ~cur_stale_q & (cur_line_q == fidx[HeightW-1:0]));

  assign ur_line  = line_ev & ~fetch_ok;
  assign ur_repl  = line_q & pending_q;
  assign cnt_sum  = {1'b0, cnt_q} + CntSumW'(ur_line) + CntSumW'(ur_repl);
  assign iss_half = queue ? q_half : pend_half_q;

  // Next-state and datapath update
  always_comb begin
    state_d     = state_q;
    pending_d   = pending_q;
    pend_src_d  = pend_src_q;
    pend_half_d = pend_half_q;
    pend_line_d = pend_line_q;
    src_next_d  = src_next_q;
    line_idx_d  = line_idx_q;
    cur_line_d  = cur_line_q;
    cur_stale_d = cur_stale_q;
    done_vld_d  = done_vld_q;
    done_line_d = done_line_q;
    disp_half_d = disp_half_q;
    cnt_d       = cnt_q;
    underrun_d  = 1'b0;
    src_d       = src_q;
    dst_d       = dst_q;
    len_d       = len_q;

    unique case (state_q)
      ST_IDLE: begin
        if (enable_i && (queue || pending_q)) begin
          state_d     = ST_REQ;
          src_d       = queue ? q_src : pend_src_q;
          dst_d       = iss_half ? AddrWidth'(HalfBytes) : '0;
          len_d       = AddrWidth'(line_bytes_i);
          cur_line_d  = queue ? q_line : pend_line_q;
          cur_stale_d = 1'b0;
          pending_d   = 1'b0;
        end
      end
      ST_REQ: begin
        if (dma.dma_ready)  state_d = ST_RUN;
        else if (!enable_i) state_d = ST_IDLE;
      end
      ST_RUN: begin
        if (!dma.dma_ready) state_d = ST_DONE_WAIT;
      end
      ST_DONE_WAIT: begin
        if (dma.dma_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Single pending slot; a newer line overwrites an unissued older one
    if (!enable_i) begin
      pending_d = 1'b0;
    end else if (queue && (state_q != ST_IDLE)) begin
      pending_d   = 1'b1;
      pend_src_d  = q_src;
      pend_half_d = q_half;
      pend_line_d = q_line;
    end

    // An in-flight transfer from the previous frame must not satisfy this frame's lines
    if (frame_ev && (state_q != ST_IDLE)) cur_stale_d = 1'b1;

    if (frame_ev)    src_next_d = fb_base_i + bpl_x;
    else if (line_q) src_next_d = src_next_q + bpl_x;

    if (frame_ev)     line_idx_d = '0;
    else if (line_ev) line_idx_d = line_idx_q + LineW'(1);

    if (line_ev) disp_half_d = fidx[0];

    if (frame_ev) begin
      done_vld_d = 1'b0;
    end else if (done_now && !cur_stale_q) begin
      done_vld_d  = 1'b1;
      done_line_d = cur_line_q;
    end

    if (frame_ev) begin
      cnt_d = '0;
    end else if (ur_line || ur_repl) begin
      cnt_d      = cnt_sum[CntWidth] ? '1 : cnt_sum[CntWidth-1:0];
      underrun_d = 1'b1;
    end

    valid_d = (state_d == ST_REQ);
    busy_d  = (state_d != ST_IDLE) | pending_d;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      pending_q   <= 1'b0;
      pend_src_q  <= '0;
      pend_half_q <= 1'b0;
      pend_line_q <= '0;
      src_next_q  <= '0;
      line_idx_q  <= '0;
      cur_line_q  <= '0;
      cur_stale_q <= 1'b0;
      done_vld_q  <= 1'b0;
      done_line_q <= '0;
      disp_half_q <= 1'b0;
      cnt_q       <= '0;
      underrun_q  <= 1'b0;
      valid_q     <= 1'b0;
      src_q       <= '0;
      dst_q       <= '0;
      len_q       <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      pend_src_q  <= pend_src_d;
      pend_half_q <= pend_half_d;
      pend_line_q <= pend_line_d;
      src_next_q  <= src_next_d;
      line_idx_q  <= line_idx_d;
      cur_line_q  <= cur_line_d;
      cur_stale_q <= cur_stale_d;
      done_vld_q  <= done_vld_d;
      done_line_q <= done_line_d;
      disp_half_q <= disp_half_d;
      cnt_q       <= cnt_d;
      underrun_q  <= underrun_d;
      valid_q     <= valid_d;
      src_q       <= src_d;
      dst_q       <= dst_d;
      len_q       <= len_d;
      busy_q      <= busy_d;
    end
  end

  assign dma.dma_valid  = valid_q;
  assign dma.dma_src    = src_q;
  assign dma.dma_dst    = dst_q;
  assign dma.dma_len    = len_q;
  assign disp_half_o    = disp_half_q;
  assign busy_o         = busy_q;
  assign underrun_o     = underrun_q;
  assign underrun_cnt_o = cnt_q;

endmodule

// File: tb/tb_video_line_fetch_sched.sv
// Bench for video_line_fetch_sched: a behavioural data mover plus per-scenario reference expectations.
// Expected fetch lists, display halves and underrun counts come from line-index arithmetic.
module tb_video_line_fetch_sched;

  localparam int unsigned AW = 64;
  localparam int unsigned HB = 16384;
  localparam int unsigned CW = 16;
`ifdef LINE_DOUBLE_EN
  localparam int DBL = 1;
`else
  localparam int DBL = 0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          enable, frame_start, line_start;
  logic [AW-1:0] fb_base;
  logic [13:0]   fb_bpl;
  logic [11:0]   fb_height;
  logic [14:0]   line_bytes;
  logic          disp_half, busy, underrun;
  logic [CW-1:0] ucnt;

  always #5 clk = ~clk;

  video_line_fetch_sched_if #(.AddrWidth(AW)) dif ();

  video_line_fetch_sched #(.AddrWidth(AW), .HalfBytes(HB), .CntWidth(CW)) u_dut (
    .clk_i(clk), .rst_ni(rst_n), .enable_i(enable), .frame_start_i(frame_start),
    .line_start_i(line_start), .fb_base_i(fb_base), .fb_bpl_i(fb_bpl),
    .fb_height_i(fb_height), .line_bytes_i(line_bytes), .dma(dif),
    .disp_half_o(disp_half), .busy_o(busy), .underrun_o(underrun), .underrun_cnt_o(ucnt)
  );

  int checks, errors;
  int mv_lat, mv_cnt, mv_cyc, ready_rise_cyc, up_cnt, vwb;
  bit mv_block, mv_busy;
  logic [AW-1:0] q_src[$], q_dst[$], q_len[$];
  int q_cyc[$];
  bit exp_half;

  // Data mover model: ready high when idle, low for mv_lat cycles after each accepted request
  initial begin
    dif.dma_ready = 1'b1;
    forever begin
      @(negedge clk);
      mv_cyc++;
      if (underrun) up_cnt++;
      if (mv_busy && dif.dma_valid) vwb++;
      if (mv_busy) begin
        if (mv_cnt == 0) begin
          dif.dma_ready = 1'b1; mv_busy = 1'b0; ready_rise_cyc = mv_cyc;
        end else begin
          dif.dma_ready = 1'b0; mv_cnt--;
        end
      end else if (dif.dma_valid && dif.dma_ready) begin
        q_src.push_back(dif.dma_src); q_dst.push_back(dif.dma_dst);
        q_len.push_back(dif.dma_len); q_cyc.push_back(mv_cyc);
        mv_busy = 1'b1; mv_cnt = mv_lat;
      end else begin
        dif.dma_ready = !mv_block;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic step(input int n = 1);
    repeat (n) begin @(negedge clk); #1; end
  endtask

  task automatic pulse_frame(input logic [AW-1:0] base, input bit with_line);
    fb_base = base; frame_start = 1'b1; line_start = with_line;
    step();
    frame_start = 1'b0; line_start = 1'b0;
  endtask

  task automatic pulse_line();
    line_start = 1'b1;
    step();
    line_start = 1'b0;
  endtask

  task automatic wait_reqs(input int n, input int budget, output bit ok);
    int b = budget;
    while (q_src.size() < n && b > 0) begin step(); b--; end
    ok = (q_src.size() >= n);
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    int b = budget;
    while (busy && b > 0) begin step(); b--; end
    ok = !busy;
  endtask

  task automatic clear_log();
    q_src.delete(); q_dst.delete(); q_len.delete(); q_cyc.delete();
  endtask

  function automatic logic [AW-1:0] rand_base();
    logic [AW-1:0] b;
    b = {$urandom(), $urandom()};
    b[2:0] = 3'b000;
    return b;
  endfunction

  function automatic logic [AW-1:0] exp_src(input logic [AW-1:0] base, input logic [13:0] bpl, input int k);
    return base + AW'(k) * AW'(bpl);
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b0; frame_start = 1'b0; line_start = 1'b0;
    fb_base = '0; fb_bpl = '0; fb_height = 12'd1; line_bytes = '0;
    step(3);
    checks++; if (dif.dma_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", dif.dma_valid); end
    checks++; if (dif.dma_src !== '0) begin errors++; $display("FAIL reset_src got %0h want 0", dif.dma_src); end
    checks++; if (dif.dma_dst !== '0) begin errors++; $display("FAIL reset_dst got %0h want 0", dif.dma_dst); end
    checks++; if (dif.dma_len !== '0) begin errors++; $display("FAIL reset_len got %0h want 0", dif.dma_len); end
    checks++; if (disp_half !== 1'b0) begin errors++; $display("FAIL reset_disp got %0b want 0", disp_half); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", busy); end
    checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL reset_underrun got %0b want 0", underrun); end
    checks++; if (ucnt !== '0) begin errors++; $display("FAIL reset_cnt got %0d want 0", ucnt); end
    rst_n = 1'b1; enable = 1'b1;
    step(2);
  endtask

  task automatic test_normal(input int iter);
    logic [AW-1:0] base;
    logic [13:0] bpl;
    int h, up0, nl, f;
    bit ok;
    if (iter == 0) begin
      base = 64'h1000_0000; bpl = 14'd2048; h = 4; line_bytes = 15'd2560; mv_lat = 10;
    end else begin
      base = rand_base(); bpl = 14'($urandom_range(1, 2047) * 8); h = $urandom_range(1, 5);
      line_bytes = 15'($urandom_range(1, 32767)); mv_lat = $urandom_range(2, 12);
    end
    mv_block = 1'b0; fb_bpl = bpl; fb_height = 12'(h);
    clear_log(); up0 = up_cnt;
    pulse_frame(base, 1'b0);
    wait_reqs(1, 40, ok);
    checks++; if (!ok) begin errors++; $display("FAIL normal_first_req got %0d reqs want 1", q_src.size()); end
    step(30);
    nl = h * (1 + DBL) + 2;
    for (int d = 0; d < nl; d++) begin
      pulse_line();
      f = d >> DBL;
      if (f < h) exp_half = ((f % 2) != 0);
      checks++; if (disp_half !== exp_half) begin errors++; $display("FAIL normal_disp line %0d got %0b want %0b", d, disp_half, exp_half); end
      step(24);
    end
    checks++; if (q_src.size() != h) begin errors++; $display("FAIL normal_req_count got %0d want %0d", q_src.size(), h); end
    for (int k = 0; k < h && k < q_src.size(); k++) begin
      checks++; if (q_src[k] !== exp_src(base, bpl, k)) begin errors++; $display("FAIL normal_src %0d got %0h want %0h", k, q_src[k], exp_src(base, bpl, k)); end
      checks++; if (q_dst[k] !== AW'((k % 2) * HB)) begin errors++; $display("FAIL normal_dst %0d got %0h want %0h", k, q_dst[k], (k % 2) * HB); end
      checks++; if (q_len[k] !== AW'(line_bytes)) begin errors++; $display("FAIL normal_len %0d got %0h want %0h", k, q_len[k], line_bytes); end
    end
    checks++; if (ucnt !== '0) begin errors++; $display("FAIL normal_cnt got %0d want 0", ucnt); end
    checks++; if (up_cnt != up0) begin errors++; $display("FAIL normal_pulses got %0d want 0", up_cnt - up0); end
  endtask

  task automatic test_underrun(input int nstarts);
    logic [AW-1:0] base;
    logic [13:0] bpl;
    int h, up0, f, exp_cnt, exp_pulses, nq, last_q;
    bit ok, ur;
    base = rand_base(); bpl = 14'($urandom_range(1, 2047) * 8); h = 4;
    line_bytes = 15'($urandom_range(1, 32767));
    fb_bpl = bpl; fb_height = 12'(h); mv_block = 1'b0; mv_lat = 100;
    clear_log(); up0 = up_cnt;
    pulse_frame(base, 1'b0);
    wait_reqs(1, 20, ok);
    checks++; if (!ok) begin errors++; $display("FAIL slow_first_req got %0d reqs want 1", q_src.size()); end
    mv_lat = 8;
    step(30);
    exp_cnt = 0; exp_pulses = 0; nq = 0; last_q = -1;
    for (int d = 0; d < nstarts; d++) begin
      f = d >> DBL; ur = 1'b0;
      if (f < h) begin
        ur = 1'b1; exp_cnt++;
        if ((DBL == 0 || (d % 2) == 1) && f + 1 < h) begin
          if (nq > 0) exp_cnt++;
          nq++; last_q = f + 1;
        end
        exp_half = ((f % 2) != 0);
      end
      if (ur) exp_pulses++;
      pulse_line();
      checks++; if (disp_half !== exp_half) begin errors++; $display("FAIL slow_disp line %0d got %0b want %0b", d, disp_half, exp_half); end
      step(2);
    end
    checks++; if (ucnt !== CW'(exp_cnt)) begin errors++; $display("FAIL slow_cnt got %0d want %0d", ucnt, exp_cnt); end
    step();
    checks++; if (up_cnt - up0 != exp_pulses) begin errors++; $display("FAIL slow_pulses got %0d want %0d", up_cnt - up0, exp_pulses); end
    wait_reqs(2, 150, ok);
    checks++; if (!ok) begin errors++; $display("FAIL slow_second_req got %0d reqs want 2", q_src.size()); end
    if (ok) begin
      checks++; if (q_cyc[1] - ready_rise_cyc != 2) begin errors++; $display("FAIL slow_issue_delay got %0d want 2", q_cyc[1] - ready_rise_cyc); end
      checks++; if (q_src[1] !== exp_src(base, bpl, last_q)) begin errors++; $display("FAIL slow_src got %0h want %0h", q_src[1], exp_src(base, bpl, last_q)); end
      checks++; if (q_dst[1] !== AW'((last_q % 2) * HB)) begin errors++; $display("FAIL slow_dst got %0h want %0h", q_dst[1], (last_q % 2) * HB); end
    end
    wait_idle(60, ok);
    checks++; if (!ok) begin errors++; $display("FAIL slow_idle got busy %0b want 0", busy); end
  endtask

  task automatic test_simul();
    logic [AW-1:0] base;
    logic [13:0] bpl;
    bit ok;
    base = rand_base(); bpl = 14'($urandom_range(1, 2047) * 8);
    fb_bpl = bpl; fb_height = 12'd3; mv_lat = 8; mv_block = 1'b0;
    clear_log();
    pulse_frame(base, 1'b1);
    checks++; if (ucnt !== '0) begin errors++; $display("FAIL simul_cnt got %0d want 0", ucnt); end
    checks++; if (disp_half !== exp_half) begin errors++; $display("FAIL simul_disp got %0b want %0b", disp_half, exp_half); end
    wait_reqs(1, 20, ok);
    checks++; if (!ok || q_src[0] !== base || q_dst[0] !== '0) begin
      errors++; $display("FAIL simul_first_req got n=%0d src %0h want src %0h dst 0", q_src.size(), ok ? q_src[0] : '0, base);
    end
    step(20);
    for (int d = 0; d < 1 + DBL; d++) begin
      pulse_line();
      exp_half = 1'b0;
      checks++; if (disp_half !== 1'b0) begin errors++; $display("FAIL simul_line0_disp got %0b want 0", disp_half); end
      step(3);
    end
    wait_reqs(2, 40, ok);
    checks++; if (!ok || q_src[1] !== exp_src(base, bpl, 1) || q_dst[1] !== AW'(HB)) begin
      errors++; $display("FAIL simul_line1_req got n=%0d src %0h want %0h dst %0h", q_src.size(), ok ? q_src[1] : '0, exp_src(base, bpl, 1), HB);
    end
    checks++; if (ucnt !== '0) begin errors++; $display("FAIL simul_cnt_after got %0d want 0", ucnt); end
    wait_idle(40, ok);
  endtask

  task automatic test_en_req();
    mv_block = 1'b1;
    step(2);
    clear_log();
    pulse_frame(rand_base(), 1'b0);
    checks++; if (dif.dma_valid !== 1'b1) begin errors++; $display("FAIL enreq_valid_up got %0b want 1", dif.dma_valid); end
    enable = 1'b0;
    step();
    checks++; if (dif.dma_valid !== 1'b0) begin errors++; $display("FAIL enreq_valid_drop got %0b want 0", dif.dma_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL enreq_busy got %0b want 0", busy); end
    step(3);
    enable = 1'b1; mv_block = 1'b0;
    step(20);
    checks++; if (q_src.size() != 0) begin errors++; $display("FAIL enreq_no_req got %0d want 0", q_src.size()); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL enreq_idle got %0b want 0", busy); end
  endtask

  task automatic test_en_run();
    logic [AW-1:0] b4;
    int vwb0;
    bit ok;
    fb_height = 12'd4; mv_lat = 30; mv_block = 1'b0;
    clear_log(); vwb0 = vwb;
    pulse_frame(rand_base(), 1'b0);
    wait_reqs(1, 20, ok);
    checks++; if (!ok) begin errors++; $display("FAIL enrun_first_req got %0d want 1", q_src.size()); end
    step(3);
    pulse_line();
    enable = 1'b0;
    step();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL enrun_busy got %0b want 1", busy); end
    step(2);
    enable = 1'b1;
    b4 = rand_base();
    pulse_frame(b4, 1'b0);
    wait_reqs(2, 80, ok);
    checks++; if (!ok) begin errors++; $display("FAIL enrun_second_req got %0d want 2", q_src.size()); end
    checks++; if (vwb != vwb0) begin errors++; $display("FAIL enrun_valid_while_busy got %0d want 0", vwb - vwb0); end
    if (ok) begin
      checks++; if (q_src[1] !== b4 || q_dst[1] !== '0) begin errors++; $display("FAIL enrun_req got src %0h dst %0h want %0h 0", q_src[1], q_dst[1], b4); end
      checks++; if (q_cyc[1] - ready_rise_cyc != 2) begin errors++; $display("FAIL enrun_issue_delay got %0d want 2", q_cyc[1] - ready_rise_cyc); end
    end
    wait_idle(60, ok);
    checks++; if (!ok) begin errors++; $display("FAIL enrun_idle got busy %0b want 0", busy); end
  endtask

  initial begin
    checks = 0; errors = 0; mv_lat = 10; mv_cnt = 0; mv_cyc = 0; ready_rise_cyc = 0;
    up_cnt = 0; vwb = 0; mv_block = 1'b0; mv_busy = 1'b0; exp_half = 1'b0;
    test_reset();
    for (int i = 0; i < 3; i++) test_normal(i);
    test_underrun(1 + DBL);
    test_underrun(2 * (1 + DBL));
    test_simul();
    test_en_req();
    test_en_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/video_line_fetch_sched.md
Name: video_line_fetch_sched

Overview:
- Scanline fetch scheduler in the bus clock domain.
- Sequences the AXI data mover that copies framebuffer lines from system memory into the 2-half (ping-pong) line buffer read by the pixel pipeline.
- Latches the frame base at frame start, walks source addresses by bytes-per-line, and alternates destination halves.
- Tells the pixel side which half to display and counts underruns, i.e. a line start arriving before that line's fetch completed.

Parameters:
- AddrWidth, 64, source/destination/length width presented to the data mover.
- HalfBytes, 16384, byte size of one line-buffer half; destination of half h = h*HalfBytes.
- CntWidth, 16, underrun counter width.

Ports:
- clk_i  in  1  bus clock
- rst_ni  in  1  reset, asynchronous, active-low
- enable_i  in  1  scheduler enable; low forces IDLE and clears pending work
- frame_start_i  in  1  single-cycle pulse, clk_i domain, start of vertical blank (before line 0)
- line_start_i  in  1  single-cycle pulse, clk_i domain, start of each active display line
- fb_base_i  in  AddrWidth  framebuffer base, 8-byte aligned; sampled only on frame_start_i
- fb_bpl_i  in  14  bytes per line, 8-byte aligned
- fb_height_i  in  12  framebuffer lines (>=1)
- line_bytes_i  in  15  bytes fetched per line
- dma_valid_o  out  1  request to data mover
- dma_ready_i  in  1  data mover idle/ready; low while a transfer runs
- dma_src_o  out  AddrWidth  source byte address
- dma_dst_o  out  AddrWidth  destination byte address in line buffer
- dma_len_o  out  AddrWidth  transfer length in bytes (zero-extended line_bytes_i)
- disp_half_o  out  1  line-buffer half the pixel pipeline reads for the current line
- busy_o  out  1  transfer outstanding or request pending
- underrun_o  out  1  single-cycle pulse on underrun
- underrun_cnt_o  out  CntWidth  saturating underrun count; cleared on frame_start_i

Behaviour:
- Reset values:
  - dma_valid_o=0, dma_src_o=0, dma_dst_o=0, dma_len_o=0.
  - disp_half_o=0, busy_o=0, underrun_o=0, underrun_cnt_o=0.
  - State IDLE, line index 0, pending=0.
- FSM states:
  - IDLE: no transfer.
  - REQ: dma_valid_o=1, held until dma_ready_i=1; acceptance occurs in that cycle.
  - RUN: wait for dma_ready_i=0, i.e. the mover is busy.
  - DONE_WAIT: wait for dma_ready_i=1; this marks completion, return to IDLE.
  - Request outputs are stable from REQ entry through acceptance.
- Frame start, when enable_i=1:
  - Latch base; set src_next = base, line index = 0, underrun_cnt_o = 0.
  - Queue fetch of line 0 into half 0.
- Line start, for line n < fb_height_i:
  - disp_half_o <= n[0] on the next cycle.
  - If line n's fetch has not yet reached DONE_WAIT->IDLE: pulse underrun_o and increment the counter, saturating at all-ones.
  - If n+1 < fb_height_i: queue fetch of line n+1 into half ~n[0].
  - Increment line index.
  - Line starts with n >= fb_height_i are ignored: no fetch, no underrun, disp_half_o unchanged.
- Queueing and address arithmetic:
  - Single pending slot. Queueing while IDLE enters REQ next cycle.
  - Queueing while busy sets pending; pending is issued the cycle after return to IDLE.
  - Queueing while pending is already set also counts an underrun; the newer line replaces the older one.
  - src for line k = base + k*fb_bpl_i, computed by accumulating fb_bpl_i modulo 2^AddrWidth.
  - dst = half*HalfBytes.
- Simultaneous frame_start_i and line_start_i: frame_start_i wins; line_start_i is dropped.
- enable_i low: next cycle goes to IDLE and clears pending.
  - If a transfer was already accepted, still wait for dma_ready_i=1 before accepting new work; busy_o stays high until then.
  - dma_valid_o drops immediately when not yet accepted.
- busy_o = (state != IDLE) | pending.

Optional Feature:
- Macro LINE_DOUBLE_EN.
- With it defined:
  - Each source line is displayed on two consecutive display lines.
  - Fetch index = display line >> 1.
  - A new fetch is queued only on line starts where the display line index is odd.
  - disp_half_o = (display line >> 1)[0].
  - The line-count limit compares display line >> 1 against fb_height_i.
- Without it: one fetch per display line as above.

Test Plan:
- Reset, then frame_start with base=0x1000_0000, bpl=2048, height=4, line_bytes=2560; mover accepts immediately and completes after 10 cycles → first request src=0x1000_0000, dst=0, len=2560.
- Four line starts, each ≥20 cycles apart → requests src 0x1000_0800/1000/1800 with dst 0x4000/0/0x4000 in that order; no fourth request; disp_half_o sequence 0,1,0,1; underrun_cnt_o=0.
- Mover held busy 100 cycles, line start at cycle 30 → underrun_o pulses once, count=1, next fetch issued the cycle after completion.
- Simultaneous frame_start and line_start pulses → only frame processing occurs; count cleared to 0; line index 0.
- enable_i dropped while in REQ before acceptance → dma_valid_o=0 next cycle, busy_o=0.
- enable_i dropped while in RUN → no new request until dma_ready_i returns high.
- LINE_DOUBLE_EN, height=2, 4 line starts → exactly 2 fetches (lines 0,1); disp_half_o 0,0,1,1.
